// File: rtl/rr_bin_arb_if.sv
// Request/grant bundle for rr_bin_arb: level requests with one-hot ack on one side,
// registered binary grant with valid/ready on the other.
interface rr_bin_arb_if #(
    parameter int IN = 4
) ();
    localparam int N = 1 << IN;

    // Handshake: out_idx transfers on any rising edge where out_valid && out_ready.
    // While out_valid && !out_ready, out_idx and out_valid hold steady.
    logic [N-1:0]  req;
    logic [N-1:0]  ack;
    logic          out_valid;
    logic          out_ready;
    logic [IN-1:0] out_idx;

    // Arbiter side.
    modport slave (
        input  req,
        input  out_ready,
        output ack,
        output out_valid,
        output out_idx
    );

    // Requesters plus downstream consumer.
    modport master (
        output req,
        output out_ready,
        input  ack,
        input  out_valid,
        input  out_idx
    );
endinterface

// File: rtl/rr_bin_arb.sv
// Round-robin arbiter over 1<<IN level requests; the winner is held as a
// registered binary index behind a valid/ready output stage.
module rr_bin_arb #(
    parameter int   IN  = 4,
    parameter logic ACT = 1'b1   // 1: req bit asserted high, 0: asserted low
) (
    input  logic         clk,
    input  logic         reset_,
    rr_bin_arb_if.slave  bus,
    output logic [0:0]   dbg_state
);
    localparam int N = 1 << IN;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t        state, state_d;
    logic [IN-1:0] idx_q, idx_d;
    logic [IN-1:0] last_q, last_d;
    logic [N-1:0]  req_act;
    logic [N-1:0]  ack_c;
    logic [IN-1:0] win;
    logic [IN-1:0] probe;
    logic          found;
    logic          load;

    assign req_act = ACT ? bus.req : ~bus.req;
    assign load    = (state == EMPTY) || bus.out_ready;

    // Search last+1 .. last+N; the IN-bit add wraps, so last itself is probed last.
    always_comb begin
        found = 1'b0;
        win   = '0;
        probe = '0;
        for (int k = 1; k <= N; k++) begin
            probe = last_q + IN'(k);
            if (!found && req_act[probe]) begin
                found = 1'b1;
                win   = probe;
            end
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx_q;
        last_d  = last_q;
        ack_c   = '0;
        if (load) begin
            if (found) begin
                ack_c[win] = 1'b1;
                idx_d      = win;
                last_d     = win;
                state_d    = FULL;
            end else begin
                state_d    = EMPTY;
            end
        end
        // A grant captured under reset would be discarded, so never ack it.
        if (!reset_) ack_c = '0;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state  <= EMPTY;
            idx_q  <= '0;
            last_q <= IN'(N - 1);
        end else begin
            state  <= state_d;
            idx_q  <= idx_d;
            last_q <= last_d;
        end
    end

    assign bus.ack       = ack_c;
    assign bus.out_valid = (state == FULL);
    assign bus.out_idx   = idx_q;
    assign dbg_state     = state;
endmodule
